// File: rtl/pipe_unpack_pkg.sv
// rtl/pipe_unpack_pkg.sv - shared constants, state encoding and lane-count helpers for the pipe width converters
//
// Package pipe_pkg, shared by the receive-side unpacker and the send-side packer.
//   PIPE_W_DATA / PIPE_W_OUT : default word and lane widths
//   pipe_state_e             : ST_IDLE / ST_SHIFT
//   lane_ratio()             : lanes per word
//   clamp_count()            : maps a final-word lane count onto 1..ratio
package pipe_pkg;

  localparam int PIPE_W_DATA = 32;
  localparam int PIPE_W_OUT  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } pipe_state_e;

  function automatic int lane_ratio(input int w_data, input int w_out);
    return w_data / w_out;
  endfunction

  // A zero count or a count beyond the word width both mean "whole word".
  function automatic int clamp_count(input int cnt, input int ratio);
    if (cnt <= 0 || cnt > ratio) return ratio;
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_unpack_if.sv
// rtl/pipe_unpack_if.sv - wide-in / lane-out valid/ready bundle for the unpacker
//
// Parameters: W_DATA (word width), W_OUT (lane width).
// Signals:
//   s_valid/s_ready/s_data/s_last/s_count : wide word input side
//   m_valid/m_ready/m_data/m_last         : lane output side
// Modports:
//   slave  : the unpacker's view (consumes words, produces lanes)
//   master : the environment's view (produces words, consumes lanes)
interface pipe_unpack_if
  import pipe_pkg::*;
#(
  parameter int W_DATA = PIPE_W_DATA,
  parameter int W_OUT  = PIPE_W_OUT
);
  localparam int RATIO = lane_ratio(W_DATA, W_OUT);
  localparam int W_CNT = $clog2(RATIO) + 1;

  logic              s_valid;
  logic              s_ready;
  logic [W_DATA-1:0] s_data;
  logic              s_last;
  logic [W_CNT-1:0]  s_count;
  logic              m_valid;
  logic              m_ready;
  logic [W_OUT-1:0]  m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, s_count, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, s_count, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/pipe_lane_mux.sv
// rtl/pipe_lane_mux.sv - combinational lane select of a packed word by emission index
//
// Parameters: W_DATA, W_OUT, W_IDX.
// Ports:
//   word : packed word, lane 0 in the LSBs
//   idx  : emission index (0 = first lane emitted)
//   lane : selected lane
// Build option PIPE_UNPACK_MSB_FIRST_EN: emission index 0 maps to the top lane
// instead of lane 0, so partial words yield their top lanes, highest first.
module pipe_lane_mux #(
  parameter int W_DATA = 32,
  parameter int W_OUT  = 8,
  parameter int W_IDX  = 3
) (
  input  logic [W_DATA-1:0] word,
  input  logic [W_IDX-1:0]  idx,
  output logic [W_OUT-1:0]  lane
);
  localparam int RATIO = W_DATA / W_OUT;

  int sel;

  always_comb begin
`ifdef PIPE_UNPACK_MSB_FIRST_EN
    sel = RATIO - 1 - int'(idx);
`else
    sel = int'(idx);
`endif
    lane = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i == sel) lane = word[i*W_OUT +: W_OUT];
    end
  end

endmodule

// File: rtl/pipe_unpack.sv
// rtl/pipe_unpack.sv - receive-side width converter, one W_DATA word out as W_OUT lanes
//
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : pipe_unpack_if.slave (s_* word input, m_* lane output)
//   o_busy  : a word is held with lanes pending
//   o_err   : sticky, a final word arrived with count 0 or count > RATIO
// Build option PIPE_UNPACK_MSB_FIRST_EN: emit the highest lane first.
module pipe_unpack
  import pipe_pkg::*;
#(
  parameter int W_DATA = PIPE_W_DATA,
  parameter int W_OUT  = PIPE_W_OUT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  pipe_unpack_if.slave bus,
  output logic         o_busy,
  output logic         o_err
);
  localparam int RATIO = lane_ratio(W_DATA, W_OUT);
  localparam int W_CNT = $clog2(RATIO) + 1;

  pipe_state_e       state_q, state_d;
  logic [W_CNT-1:0]  idx_q, idx_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_DATA-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [W_OUT-1:0]  data_q, data_d;
  logic              mlast_q, mlast_d;
  logic              err_q, err_d;

  logic              final_lane, s_ready_c, accept, bad_cnt;
  logic [W_CNT-1:0]  in_cnt, idx_nxt, mux_idx;
  logic [W_DATA-1:0] mux_word;
  logic [W_OUT-1:0]  mux_lane;

  // The next lane is fetched a cycle early so m_data is a plain register:
  // either lane 0 of the incoming word or lane idx+1 of the held word.
  pipe_lane_mux #(.W_DATA(W_DATA), .W_OUT(W_OUT), .W_IDX(W_CNT)) u_mux (
    .word (mux_word),
    .idx  (mux_idx),
    .lane (mux_lane)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    last_d  = last_q;
    data_d  = data_q;
    mlast_d = mlast_q;
    err_d   = err_q;

    idx_nxt    = idx_q + W_CNT'(1);
    final_lane = (idx_q == cnt_q - W_CNT'(1));
    // Ready on the final-lane handshake lets the next word slide in without a bubble.
    s_ready_c  = !i_reset && ((state_q == ST_IDLE) ||
                              (final_lane && bus.m_ready));
    accept     = bus.s_valid && s_ready_c;
    in_cnt     = bus.s_last ? W_CNT'(clamp_count(int'(bus.s_count), RATIO)) : W_CNT'(RATIO);
    bad_cnt    = bus.s_last && ((bus.s_count == '0) || (int'(bus.s_count) > RATIO));
    mux_word   = accept ? bus.s_data : word_q;
    mux_idx    = accept ? '0 : idx_nxt;

    if (accept) begin
      state_d = ST_SHIFT;
      word_d  = bus.s_data;
      last_d  = bus.s_last;
      cnt_d   = in_cnt;
      idx_d   = '0;
      data_d  = mux_lane;
      mlast_d = bus.s_last && (in_cnt == W_CNT'(1));
      if (bad_cnt) err_d = 1'b1;
    end else if (state_q == ST_SHIFT && bus.m_ready) begin
      if (final_lane) begin
        state_d = ST_IDLE;
        data_d  = '0;
        mlast_d = 1'b0;
      end else begin
        idx_d   = idx_nxt;
        data_d  = mux_lane;
        mlast_d = last_q && (idx_nxt == cnt_q - W_CNT'(1));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      mlast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      last_q  <= last_d;
      data_q  <= data_d;
      mlast_q <= mlast_d;
      err_q   <= err_d;
    end
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = (state_q == ST_SHIFT);
  assign bus.m_data  = data_q;
  assign bus.m_last  = mlast_q;
  assign o_busy      = (state_q == ST_SHIFT);
  assign o_err       = err_q;

endmodule

// File: tb/tb_pipe_unpack.sv
// tb/tb_pipe_unpack.sv - directed self-checking bench for pipe_unpack (W_DATA=32, W_OUT=8)
module tb_pipe_unpack;

  logic i_clk;
  logic i_reset;
  logic o_busy;
  logic o_err;
  int   checks;
  int   failures;

  pipe_unpack_if #(.W_DATA(32), .W_OUT(8)) bus ();

  pipe_unpack #(.W_DATA(32), .W_OUT(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic lane(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.m_data),  32'(d));
    chk({tag, "_last"},  32'(bus.m_last),  32'(l));
  endtask

  task automatic idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_busy"},  32'(o_busy),      32'd0);
    chk({tag, "_ready"}, 32'(bus.s_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] c);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_count = c;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_count = '0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    chk("rst_sready", 32'(bus.s_ready), 32'd0);
    chk("rst_mvalid", 32'(bus.m_valid), 32'd0);
    chk("rst_mdata",  32'(bus.m_data),  32'd0);
    chk("rst_mlast",  32'(bus.m_last),  32'd0);
    chk("rst_busy",   32'(o_busy),      32'd0);
    chk("rst_err",    32'(o_err),       32'd0);
    i_reset = 1'b0;
    #1;
    chk("post_rst_sready", 32'(bus.s_ready), 32'd1);

`ifndef PIPE_UNPACK_MSB_FIRST_EN
    // 1: full last word
    send(32'h44332211, 1'b1, 3'd4);
    tick(); bus.s_valid = 1'b0;
    lane("t1_l0", 8'h11, 1'b0);
    chk("t1_sready_mid", 32'(bus.s_ready), 32'd0);
    tick(); lane("t1_l1", 8'h22, 1'b0);
    tick(); lane("t1_l2", 8'h33, 1'b0);
    tick(); lane("t1_l3", 8'h44, 1'b1);
    chk("t1_sready_final", 32'(bus.s_ready), 32'd1);
    tick(); idle("t1_idle");

    // 2: back-to-back, no bubble
    send(32'hDDCCBBAA, 1'b0, 3'd0);
    tick();
    send(32'h00000055, 1'b1, 3'd1);
    lane("t2_l0", 8'hAA, 1'b0);
    chk("t2_sready_aa", 32'(bus.s_ready), 32'd0);
    tick(); lane("t2_l1", 8'hBB, 1'b0);
    tick(); lane("t2_l2", 8'hCC, 1'b0);
    tick(); lane("t2_l3", 8'hDD, 1'b0);
    chk("t2_sready_dd", 32'(bus.s_ready), 32'd1);
    tick(); bus.s_valid = 1'b0;
    lane("t2_w1", 8'h55, 1'b1);
    tick(); idle("t2_idle");

    // 3: backpressure on 0x22
    send(32'h44332211, 1'b1, 3'd4);
    tick(); bus.s_valid = 1'b0;
    lane("t3_l0", 8'h11, 1'b0);
    tick(); lane("t3_l1", 8'h22, 1'b0);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      lane("t3_hold", 8'h22, 1'b0);
      chk("t3_hold_sready", 32'(bus.s_ready), 32'd0);
    end
    bus.m_ready = 1'b1;
    tick(); lane("t3_l2", 8'h33, 1'b0);
    tick(); lane("t3_l3", 8'h44, 1'b1);
    tick(); idle("t3_idle");

    // 4: count=0 treated as full word, sticky error
    chk("t4_err_before", 32'(o_err), 32'd0);
    send(32'h44332211, 1'b1, 3'd0);
    tick(); bus.s_valid = 1'b0;
    lane("t4_l0", 8'h11, 1'b0);
    chk("t4_err_set", 32'(o_err), 32'd1);
    tick(); lane("t4_l1", 8'h22, 1'b0);
    tick(); lane("t4_l2", 8'h33, 1'b0);
    tick(); lane("t4_l3", 8'h44, 1'b1);
    tick();
    send(32'h000000AB, 1'b1, 3'd1);
    tick(); bus.s_valid = 1'b0;
    lane("t4_good", 8'hAB, 1'b1);
    tick(); idle("t4_idle");
    chk("t4_err_sticky", 32'(o_err), 32'd1);

    // 5: reset mid-word
    send(32'h44332211, 1'b1, 3'd4);
    tick(); bus.s_valid = 1'b0;
    lane("t5_l0", 8'h11, 1'b0);
    tick(); lane("t5_l1", 8'h22, 1'b0);
    i_reset = 1'b1;
    #1;
    chk("t5_sready_in_rst", 32'(bus.s_ready), 32'd0);
    tick();
    chk("t5_mvalid", 32'(bus.m_valid), 32'd0);
    chk("t5_busy",   32'(o_busy),      32'd0);
    chk("t5_err_clr", 32'(o_err),      32'd0);
    i_reset = 1'b0;
    #1;
    chk("t5_sready_after", 32'(bus.s_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_tail", 32'(bus.m_valid), 32'd0);
    end

    // partial last word and clamp of count > RATIO
    send(32'h44332211, 1'b1, 3'd2);
    tick(); bus.s_valid = 1'b0;
    lane("p2_l0", 8'h11, 1'b0);
    tick(); lane("p2_l1", 8'h22, 1'b1);
    tick(); idle("p2_idle");
    chk("p2_err", 32'(o_err), 32'd0);
    send(32'h88776655, 1'b1, 3'd7);
    tick(); bus.s_valid = 1'b0;
    lane("c7_l0", 8'h55, 1'b0);
    chk("c7_err", 32'(o_err), 32'd1);
    tick(); lane("c7_l1", 8'h66, 1'b0);
    tick(); lane("c7_l2", 8'h77, 1'b0);
    tick(); lane("c7_l3", 8'h88, 1'b1);
    tick(); idle("c7_idle");
`else
    // 6: MSB-first build
    send(32'h44332211, 1'b1, 3'd4);
    tick(); bus.s_valid = 1'b0;
    lane("t6_l0", 8'h44, 1'b0);
    tick(); lane("t6_l1", 8'h33, 1'b0);
    tick(); lane("t6_l2", 8'h22, 1'b0);
    tick(); lane("t6_l3", 8'h11, 1'b1);
    tick(); idle("t6_idle");
    send(32'h44332211, 1'b1, 3'd2);
    tick(); bus.s_valid = 1'b0;
    lane("t6p_l0", 8'h44, 1'b0);
    tick(); lane("t6p_l1", 8'h33, 1'b1);
    tick(); idle("t6p_idle");
    do_reset();
    idle("t6_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_unpack.md
Name: pipe_unpack

Overview:
Receive-side width converter for the W_DATA-wide valid/ready pipe. It accepts packed words (lane 0 in the LSBs) and emits them one W_OUT-wide lane per cycle. It honours a lane count on the final word of a packet and passes packet boundaries through as m_last. It sits between the wide pipe fabric and byte-oriented consumers.

Parameters:
- W_DATA, 32, input word width; must be an integer multiple of W_OUT.
- W_OUT, 8, output lane width.
- RATIO (localparam), W_DATA/W_OUT, lanes per word.
- W_CNT (localparam), $clog2(RATIO)+1, width of s_count.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept a word this cycle.
- s_data  input  W_DATA  packed word, lane 0 = bits [W_OUT-1:0].
- s_last  input  1  word is the final word of a packet.
- s_count  input  W_CNT  valid lanes in the final word, 1..RATIO; ignored when s_last=0.
- m_valid  output  1  output lane valid.
- m_ready  input  1  consumer accepts the lane.
- m_data  output  W_OUT  current lane.
- m_last  output  1  final lane of the packet.
- o_busy  output  1  word held, lanes still pending.
- o_err  output  1  sticky; set on a last word with s_count=0 or s_count>RATIO.

Behaviour:
- Reset (synchronous, i_reset=1 at a clock edge): m_valid=0, m_last=0, m_data=0, o_busy=0, o_err=0, lane index=0, state=IDLE. s_ready is 0 while i_reset is high and 1 in the first cycle after reset.
- States:
  - IDLE: s_ready=1, m_valid=0.
  - SHIFT: a word is held; m_valid=1.
- Accept: s_valid & s_ready at an edge.
  - Registers s_data, s_last and the effective count (RATIO when s_last=0).
  - Lane index is set to 0; state goes to SHIFT.
- Latency: the first lane appears on m_data/m_valid the cycle after acceptance, with all outputs registered.
- In SHIFT, m_data = held word lane[idx]. Each m_valid & m_ready edge advances idx by one.
- Final lane of the held word is idx == count-1.
  - m_last = held_last & final lane.
  - s_ready = 1 in SHIFT only on the final lane when m_ready=1. This is the pass-through for back-to-back words.
- Transition on final-lane handshake:
  - If a new word is accepted in the same cycle, stay in SHIFT with idx=0. There is no bubble, giving a sustained throughput of 1 lane/cycle.
  - Otherwise go to IDLE.
- Backpressure: while m_valid=1 and m_ready=0, m_data, m_last and idx hold stable and s_ready=0.
- Bad count on a last word:
  - s_count=0 is treated as RATIO; s_count>RATIO is clamped to RATIO.
  - o_err sets and stays set until reset.
- Partial last word: lanes >= count are never emitted.
- o_busy = (state==SHIFT).
- Reset mid-word: the held word and remaining lanes are discarded; no m_last is emitted for the truncated packet.
- m_ready=1 with m_valid=0 is harmless and has no effect.

Optional Feature:
- PIPE_UNPACK_MSB_FIRST_EN defined: lanes are emitted from lane RATIO-1 down to lane 0. For a partial last word, the emitted lanes are the top count lanes, highest first.
- Not defined: LSB-first order (lane 0 first), as described above.
- Handshake, timing and m_last rules are identical in both builds.

Decomposition:
- Package pipe_pkg holds:
  - lane-count helper function (RATIO computation, count clamp);
  - state enum constants ST_IDLE/ST_SHIFT;
  - default W_DATA=32, W_OUT=8 constants shared with the send-side packer.
- One sub-module, pipe_lane_mux: combinational lane select of a W_DATA word by index, honouring the macro order. All state lives in pipe_unpack.

Test Plan (W_DATA=32, W_OUT=8):
1. s_data=0x44332211, s_last=1, s_count=4, m_ready=1 -> m_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after accept; m_last only with 0x44; then IDLE, s_ready=1.
2. Back-to-back: 0xDDCCBBAA (last=0), then 0x00000055 (last=1, count=1) with s_valid held -> 0xAA,0xBB,0xCC,0xDD,0x55 with no bubble; second word accepted on the 0xDD cycle; m_last only on 0x55.
3. m_ready=0 for 3 cycles while 0x22 is presented -> m_data=0x22, m_valid=1, s_ready=0 held for those 3 cycles; 0x33 follows after m_ready returns.
4. 0x44332211, last=1, count=0 -> four lanes emitted, m_last on 0x44; o_err=1 and it stays 1 after a subsequent good packet, until i_reset.
5. i_reset pulsed after 0x11,0x22 are consumed -> next cycle m_valid=0, o_busy=0; 0x33/0x44 are never emitted; s_ready=1 in the first cycle after reset drops.
6. PIPE_UNPACK_MSB_FIRST_EN defined: 0x44332211 with count=4 -> 0x44,0x33,0x22,0x11; with count=2 -> 0x44,0x33 and m_last on 0x33.
